// File: rtl/uriscv_irq_ctrl.sv
// Machine-level external interrupt controller: synchronised level/edge sources,
// fixed-priority arbitration and a claim/complete register port feeding the core intr_i.
module uriscv_irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [2:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic               intr_o
);

    localparam logic [2:0] A_PEND  = 3'd0;
    localparam logic [2:0] A_ENA   = 3'd1;
    localparam logic [2:0] A_EDGE  = 3'd2;
    localparam logic [2:0] A_CLAIM = 3'd3;
    localparam logic [2:0] A_INSVC = 3'd4;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s, s_d, edg;
    logic [NUM_SRC-1:0] pend_q, ena_q, edge_q, insvc_q;
    logic [NUM_SRC-1:0] pend_d, insvc_d, elig, mode_chg;
    logic [NUM_SRC-1:0] claim_oh, cmpl_oh;
    logic [4:0]         claim_id;
    logic               found;
    logic               do_claim, do_cmpl, wr_ena, wr_edge;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign unused_wdata = ^wdata_i[31:NUM_SRC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= s;
        end
    end

    assign s   = sync_q[SYNC_STAGES-1];
    assign edg = s & ~s_d;

    assign do_claim = req_i && !we_i && (addr_i == A_CLAIM);
    assign do_cmpl  = req_i &&  we_i && (addr_i == A_CLAIM);
    assign wr_ena   = req_i &&  we_i && (addr_i == A_ENA);
    assign wr_edge  = req_i &&  we_i && (addr_i == A_EDGE);

    assign elig = pend_q & ena_q & ~insvc_q;

    // Lowest index wins; claim_oh only fires when a claim read actually happens.
    always_comb begin
        claim_id = '0;
        claim_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && !found) begin
                found    = 1'b1;
                claim_id = 5'(i + 1);
                claim_oh[i] = do_claim;
            end
        end
    end

    // IDs 0 and above NUM_SRC never match, so they fall out as no-ops.
    always_comb begin
        cmpl_oh = '0;
        for (int i = 0; i < NUM_SRC; i++)
            cmpl_oh[i] = do_cmpl && (wdata_i[4:0] == 5'(i + 1));
    end

    assign mode_chg = wr_edge ? (edge_q ^ wdata_i[NUM_SRC-1:0]) : '0;

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_q[i]) pend_d[i] = edg[i] | (pend_q[i] & ~claim_oh[i]);
            else           pend_d[i] = s[i];
        end
        pend_d = pend_d & ~mode_chg;
    end

    assign insvc_d = (insvc_q | claim_oh) & ~cmpl_oh;

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            A_PEND:  rd_mux = {{(32-NUM_SRC){1'b0}}, pend_q};
            A_ENA:   rd_mux = {{(32-NUM_SRC){1'b0}}, ena_q};
            A_EDGE:  rd_mux = {{(32-NUM_SRC){1'b0}}, edge_q};
            A_CLAIM: rd_mux = {27'd0, claim_id};
            A_INSVC: rd_mux = {{(32-NUM_SRC){1'b0}}, insvc_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            ena_q   <= '0;
            edge_q  <= '0;
            insvc_q <= '0;
            intr_o  <= 1'b0;
            ack_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
            intr_o  <= |elig;
            ack_o   <= req_i;
            rdata_o <= (req_i && !we_i) ? rd_mux : '0;
            if (wr_ena)  ena_q  <= wdata_i[NUM_SRC-1:0];
            if (wr_edge) edge_q <= wdata_i[NUM_SRC-1:0];
        end
    end

endmodule

// File: doc/uriscv_irq_ctrl.md
Name: uriscv_irq_ctrl

Overview:
Machine-level external interrupt controller that shares the single core external-interrupt input among NUM_SRC peripheral sources. It synchronises raw sources and latches them as level- or edge-triggered pending bits. A fixed-priority arbiter selects the winner, and a claim/complete handshake ensures each source is serviced exactly once. The controller sits between the SoC peripherals and the core's intr_i. Firmware accesses it through a simple memory-mapped register port, entered from the CSR exception path.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31); source IDs are 1..NUM_SRC, and ID 0 means "none".
SYNC_STAGES, 2, depth of the input synchroniser flop chain (>=1).

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
irq_src_i  input  NUM_SRC  raw interrupt sources, asynchronous to clk, active-high
req_i  input  1  register access request, single-cycle strobe
we_i  input  1  1 = write, 0 = read; qualified by req_i
addr_i  input  3  word address of the register
wdata_i  input  32  write data
rdata_o  output  32  read data, valid when ack_o = 1
ack_o  output  1  access acknowledge
intr_o  output  1  to core intr_i; level, active-high

Behaviour:
- Reset (async, rst_n = 0): all synchroniser flops, pending, enable, edge-mode, in-service, ack_o, rdata_o and intr_o go to 0. Reset mid-access aborts the access with no ack.
- Synchroniser: each source passes through SYNC_STAGES flops to give s[i]. A delayed copy s_d[i] is kept, and edge[i] = s[i] & ~s_d[i].
- Pending, level mode (EDGE[i] = 0): pend_q[i] <= s[i]. A claim does not clear it; the source must deassert.
- Pending, edge mode (EDGE[i] = 1): pend_q[i] is set on edge[i] and cleared by a claim of ID i+1. If a claim and a new edge land in the same cycle, set wins and pend_q stays 1.
- Writing EDGE clears pend_q for every bit whose mode changes.
- Eligibility: elig = pend_q & ENABLE & ~insvc_q.
- intr_o is registered: intr_o <= |elig.
- Latency: a level source rising at cycle t drives intr_o high at t + SYNC_STAGES + 2 (enabled, not in service).
- Arbitration: fixed priority, lowest index wins. claim_id = winner index + 1, or 0 when elig = 0.
- Register map (word address):
  - 0 PENDING, RO, pend_q.
  - 1 ENABLE, RW.
  - 2 EDGE, RW.
  - 3 CLAIM/COMPLETE.
  - 4 INSERVICE, RO, insvc_q.
  - 5..7 read 0; writes ignored.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Claim read (addr 3): returns claim_id computed in the request cycle. If nonzero, insvc_q[id-1] is set at that clock edge (and edge-mode pending is cleared there). Reading with elig = 0 returns 0 with no side effects.
- Complete write (addr 3): wdata_i[4:0] = ID clears insvc_q[ID-1]. An ID of 0, an ID > NUM_SRC, or an ID not in service is ignored.
- Bus handshake:
  - ack_o pulses for exactly one cycle, the cycle after req_i.
  - rdata_o carries read data with ack_o and is 0 otherwise.
  - Back-to-back requests are legal; each is acked in order.
  - Writes take effect at the req_i clock edge.
- Disabling a source (ENABLE bit = 0) masks it from elig and intr_o but keeps its pending and in-service state.
- While a source is in service it cannot re-win, but other sources can still raise intr_o (nesting is allowed).

Test Plan:
- Reset with irq_src_i = 8'hFF:
  - Required: intr_o, ack_o and rdata_o stay 0 throughout reset.
  - Required: after release with ENABLE = 0, PENDING reads 8'hFF and intr_o stays 0.
- Level source 3 with ENABLE = 8'h08, src[3] rising at cycle t:
  - Required: intr_o = 1 at t + 4.
  - Required: claim reads 4, INSERVICE = 8'h08, and intr_o falls the following cycle.
  - Required: writing 4 to addr 3 while src[3] is still high brings intr_o back to 1 two cycles later.
- Priority, edge mode on sources 1 and 5 (EDGE = ENABLE = 8'h22), both pulsed at once:
  - Required: successive claims return 2, then 6, then 0.
  - Required: PENDING = 0 after both claims.
- Simultaneous claim and new edge on source 0 (edge mode):
  - Required: claim returns 1 and pending stays 1.
  - Required: after completing ID 1, intr_o re-asserts.
- Illegal completes:
  - Stimulus: write 0, 9 and 3 to addr 3, with only ID 2 in service.
  - Required: INSERVICE unchanged.
  - Required: reads of addr 6 return 0, and every access gets exactly one ack_o pulse one cycle later.
- Async reset asserted while src[2] is in service and a req_i is in flight:
  - Required: no ack_o is issued.
  - Required: all registers read 0 after release.
